// File: rtl/ldst_pkg.sv
// Shared load/store definitions: size encodings, tracking-entry layout, error rule.
package ldst_pkg;

    localparam int DATA_W    = 32;
    localparam int TAG_MAX_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Tag field is sized for the widest supported tag; narrower tags are zero-extended.
    typedef struct packed {
        logic [TAG_MAX_W-1:0] tag;
        logic [1:0]           size;
        logic                 uns;
        logic [1:0]           off;
        logic                 err;
    } ld_entry_t;

    function automatic logic ld_bad_access(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) || (size == SZ_HALF && off[0]) ||
               (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Issue, memory-bus and writeback signals of the load unit; slave = load unit side.
interface load_unit_if #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4
);
    logic              iss_valid;
    logic              iss_ready;
    logic [ADDR_W-1:0] iss_addr;
    logic [1:0]        iss_size;
    logic              iss_unsigned;
    logic [TAG_W-1:0]  iss_tag;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic [TAG_W-1:0]  wb_tag;
    logic              wb_err;

    modport slave (
        input  iss_valid, iss_addr, iss_size, iss_unsigned, iss_tag,
        output iss_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output wb_valid, wb_data, wb_tag, wb_err
    );

    modport master (
        output iss_valid, iss_addr, iss_size, iss_unsigned, iss_tag,
        input  iss_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  wb_valid, wb_data, wb_tag, wb_err
    );
endinterface

// File: rtl/load_unit_align.sv
// Combinational lane extractor: picks byte/half/word from a bus word and sign/zero-extends it.
module load_align
    import ldst_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] data_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[8*off_i +: 8];
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = {{24{~uns_i & byte_v[7]}}, byte_v};
            SZ_HALF: data_o = {{16{~uns_i & half_v[15]}}, half_v};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/load_unit.sv
// In-order load unit: word-aligned bus requests, up to DEPTH outstanding, writeback 1 cycle after response.
// Issue stalls when flushing or when queued+dropped loads reach DEPTH; responses are never backpressured.
module load_unit
    import ldst_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    load_unit_if.slave       lu,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] inflight
);
    localparam int PTR_W = $clog2(DEPTH);

    ld_entry_t         fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d, drop_q, drop_d;
    logic              wb_valid_q, wb_valid_d, wb_err_q, wb_err_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic              can_issue, fire, resp, drop_resp, pop;
    ld_entry_t         head, new_entry;
    logic [31:0]       aligned;

    assign inflight  = occ_q + drop_q;
    assign busy      = (inflight != '0);
    assign can_issue = ~flush & (inflight < CNT_W'(DEPTH));

    assign lu.mem_req_valid = lu.iss_valid & can_issue;
    assign lu.iss_ready     = lu.mem_req_ready & can_issue;
    assign lu.mem_req_addr  = {lu.iss_addr[ADDR_W-1:2], 2'b00};

    assign fire      = lu.iss_valid & lu.iss_ready;
    assign resp      = lu.mem_resp_valid;
    // Responses owed to flushed loads are consumed before any live entry.
    assign drop_resp = resp & (drop_q != '0);
    assign pop       = resp & (drop_q == '0) & (occ_q != '0);
    assign head      = fifo_q[rd_ptr_q];

    assign new_entry = '{tag:  TAG_MAX_W'(lu.iss_tag),
                         size: lu.iss_size,
                         uns:  lu.iss_unsigned,
                         off:  lu.iss_addr[1:0],
                         err:  ld_bad_access(lu.iss_size, lu.iss_addr[1:0])};

    load_align u_align (
        .word_i (lu.mem_resp_data),
        .off_i  (head.off),
        .size_i (head.size),
        .uns_i  (head.uns),
        .data_o (aligned)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        drop_d     = drop_q;
        wb_valid_d = pop & ~flush;
        wb_data_d  = wb_data_q;
        wb_tag_d   = wb_tag_q;
        wb_err_d   = wb_err_q;
        if (flush) begin
            occ_d    = '0;
            rd_ptr_d = wr_ptr_q;
            drop_d   = drop_q + occ_q - CNT_W'(resp);
        end else begin
            if (fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occ_d  = occ_q + CNT_W'(fire) - CNT_W'(pop);
            drop_d = drop_q - CNT_W'(drop_resp);
        end
        if (wb_valid_d) begin
            wb_data_d = head.err ? 32'h0 : aligned;
            wb_tag_d  = head.tag[TAG_W-1:0];
            wb_err_d  = head.err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            drop_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_tag_q   <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            drop_q     <= drop_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_tag_q   <= wb_tag_d;
            wb_err_q   <= wb_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) fifo_q[wr_ptr_q] <= new_entry;
    end

    assign lu.wb_valid = wb_valid_q;
    assign lu.wb_data  = wb_data_q;
    assign lu.wb_tag   = wb_tag_q;
    assign lu.wb_err   = wb_err_q;

    a_resp_owed: assert property (@(posedge clk) disable iff (!rst_n)
        lu.mem_resp_valid |-> (occ_q != '0 || drop_q != '0));
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Successor to the single-shot load block. Accepts load micro-ops from the issue stage and sends word-aligned read requests to the data bus.
- Tracks up to DEPTH outstanding loads in order, then formats returned words (byte/half/word, signed or unsigned) and writes them back tagged.
- Supports pipeline flush, misaligned-access error reporting, and a busy/occupancy status.
- Sits between the issue queue and the data-memory bus adapter.

Parameters:
- ADDR_W, 32, address width.
- TAG_W, 4, writeback destination/ROB tag width.
- DEPTH, 4, maximum outstanding loads (power of 2, ≥2).
- CNT_W, $clog2(DEPTH+1), width of the in-flight counter (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  load offered by issue stage
- iss_ready  out  1  load accepted this cycle (fire = iss_valid & iss_ready)
- iss_addr  in  ADDR_W  byte address
- iss_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- iss_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- iss_tag  in  TAG_W  destination tag
- mem_req_valid  out  1  bus read request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  ADDR_W  iss_addr with [1:0] forced to 0
- mem_resp_valid  in  1  read data returned; responses arrive in request order, no backpressure
- mem_resp_data  in  32  returned word
- wb_valid  out  1  one-cycle writeback pulse
- wb_data  out  32  formatted load result
- wb_tag  out  TAG_W  tag of the completed load
- wb_err  out  1  misaligned or illegal-size load
- flush  in  1  discard all in-flight loads
- busy  out  1  inflight != 0
- inflight  out  CNT_W  queued entries plus pending drops

Behaviour:
- Reset (async, rst_n=0): queue empty, drop_cnt=0, wb_valid=0, wb_data=0, wb_tag=0, wb_err=0, busy=0, inflight=0. Reset mid-operation abandons all entries; the bus side must also be reset.
- Request path (combinational pass-through):
  - mem_req_valid = iss_valid & ~flush & (inflight < DEPTH).
  - iss_ready = mem_req_ready & ~flush & (inflight < DEPTH).
  - Issue fire pushes {tag, size, unsigned, addr[1:0], err} into the tracking FIFO.
- Error detection at issue:
  - err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0).
  - Erroneous loads are still requested so response ordering is preserved.
- Response handling: on mem_resp_valid,
  - If drop_cnt>0: decrement drop_cnt; discard the data; no writeback.
  - Else: pop the FIFO head; register the result next cycle (wb_valid=1, latency 1 cycle from response).
  - Formatting: byte lane = addr[1:0] (byte) or addr[1] (half). Extend to 32 bits by sign or zero according to iss_unsigned.
  - If err: wb_data=0, wb_err=1.
- mem_resp_valid with empty FIFO and drop_cnt==0 is a protocol violation; simulation assertion only.
- Flush in a cycle:
  - No issue fire.
  - drop_cnt_next = drop_cnt + occ - (mem_resp_valid ? 1 : 0); FIFO emptied.
  - Any writeback registered in the flush cycle is suppressed (wb_valid=0 next cycle).
- New issues are allowed while drop_cnt>0. inflight = occ + drop_cnt bounds the total, so responses can never be misattributed.
- Simultaneous issue fire and response pop: occ unchanged; pointers advance independently. Full plus pop in the same cycle still blocks issue (conservative; the full check uses current inflight).
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH; occ is tracked by a separate counter.

Decomposition:
- Shared package (ldst_pkg): size encodings SZ_BYTE/SZ_HALF/SZ_WORD, the load-entry struct {tag, size, uns, off, err}, and the data width constant 32.
- One natural sub-module: load_align (combinational extractor: word, offset, size, unsigned -> 32-bit result).

Test Plan:
- Reset then 1 load (addr 0x104, word, tag 3), mem_req_ready=1, response 0xDEADBEEF two cycles later -> mem_req_addr 0x104; one cycle after the response: wb_valid=1, wb_data=0xDEADBEEF, wb_tag=3, wb_err=0; busy returns to 0.
- Byte loads at offsets 0..3 of word 0x80FF7F01, signed then unsigned -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80 signed; unsigned gives 0x01, 0x7F, 0xFF, 0x80 zero-extended. Half at offset 2 signed -> 0xFFFF80FF.
- Issue 5 loads with DEPTH=4 and responses held -> 4 accepted, iss_ready=0 on the 5th, inflight=4. Return 4 in order -> tags written back in issue order; the 5th is then accepted.
- 3 loads outstanding, flush asserted together with one response -> no wb for that response; drop_cnt=2. Issue tag 9, then return 3 responses -> only the third produces wb with tag 9.
- Half load at addr 0x3 and size=11 at 0x0 -> requests 0x0 each; wb_err=1, wb_data=0.
- Assert rst_n=0 with 2 loads outstanding -> all outputs zero immediately (asynchronous), inflight=0.
